// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the program loader.
// master drives the byte stream; slave is the loader itself.
interface prog_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       mem_we;
    logic [9:0] mem_addr;
    logic [9:0] mem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: parses SYNC/LEN/words/CSUM frames and writes 10-bit words to program memory.
// One WRITE cycle per word; in_ready drops during WRITE, DONE and ERR.
module prog_loader #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         cpu_rst,
    output logic         load_done,
    output logic         load_err,
    prog_loader_if.slave bus
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI,
        S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t          state, state_nxt;
    logic [9:0]      len;
    logic [9:0]      word;
    logic [9:0]      word_idx;
    logic [7:0]      csum;
    logic [CW-1:0]   idle_cnt;
    logic            xfer;
    logic            waiting;
    logic            timed_out;

    assign waiting   = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA_LO) ||
                       (state == S_DATA_HI) || (state == S_CSUM);
    assign xfer      = bus.in_valid && bus.in_ready;
    assign timed_out = waiting && !xfer && (idle_cnt == CW'(TIMEOUT_CYC - 1));

    assign bus.in_ready  = waiting || (state == S_IDLE);
    assign bus.mem_we    = (state == S_WRITE);
    assign bus.mem_addr  = (state == S_WRITE) ? word_idx : 10'd0;
    assign bus.mem_wdata = (state == S_WRITE) ? word : 10'd0;
    assign cpu_rst       = (state != S_DONE);
    assign load_done     = (state == S_DONE);
    assign load_err      = (state == S_ERR);

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (xfer && bus.in_data == SYNC_BYTE) state_nxt = S_LEN_LO;
            S_LEN_LO:  if (xfer) state_nxt = S_LEN_HI;
            S_LEN_HI: begin
                if (xfer) begin
                    if (bus.in_data[7:2] != 6'd0)                  state_nxt = S_ERR;
                    else if ({bus.in_data[1:0], len[7:0]} == 10'd0) state_nxt = S_CSUM;
                    else                                           state_nxt = S_DATA_LO;
                end
            end
            S_DATA_LO: if (xfer) state_nxt = S_DATA_HI;
            S_DATA_HI: begin
                if (xfer) state_nxt = (bus.in_data[7:2] != 6'd0) ? S_ERR : S_WRITE;
            end
            S_WRITE:   state_nxt = (word_idx == len - 10'd1) ? S_CSUM : S_DATA_LO;
            S_CSUM:    if (xfer) state_nxt = (bus.in_data == csum) ? S_DONE : S_ERR;
            S_DONE,
            S_ERR:     if (start) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        // An idle gap inside a frame overrides whatever the byte decode chose.
        if (timed_out) state_nxt = S_ERR;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            len      <= 10'd0;
            word     <= 10'd0;
            word_idx <= 10'd0;
            csum     <= 8'd0;
            idle_cnt <= '0;
        end else begin
            if (waiting && !xfer) idle_cnt <= idle_cnt + CW'(1);
            else                  idle_cnt <= '0;

            case (state)
                S_IDLE: begin
                    word_idx <= 10'd0;
                    csum     <= 8'd0;
                end
                S_LEN_LO: if (xfer) begin
                    len[7:0] <= bus.in_data;
                    csum     <= csum + bus.in_data;
                end
                S_LEN_HI: if (xfer) begin
                    len[9:8] <= bus.in_data[1:0];
                    csum     <= csum + bus.in_data;
                end
                S_DATA_LO: if (xfer) begin
                    word[7:0] <= bus.in_data;
                    csum      <= csum + bus.in_data;
                end
                S_DATA_HI: if (xfer) begin
                    word[9:8] <= bus.in_data[1:0];
                    csum      <= csum + bus.in_data;
                end
                S_WRITE: word_idx <= word_idx + 10'd1;
                S_DONE,
                S_ERR: if (start) begin
                    word_idx <= 10'd0;
                    csum     <= 8'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised frame stimulus for prog_loader; a frame-level model feeds a write/outcome scoreboard.
module tb_prog_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic cpu_rst, load_done, load_err;

    prog_loader_if bus ();

    prog_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYC(1000)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cpu_rst   (cpu_rst),
        .load_done (load_done),
        .load_err  (load_err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] addr;
        logic [9:0] data;
    } wr_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    wr_t        exp_wr[$];
    logic [1:0] exp_out[$];   // {done, err}
    logic [7:0] frame[$];
    int         consumed;
    int         max_gap = 0;
    logic       prev_end = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write and every DONE/ERR entry is matched against the queues.
    always @(negedge clk) begin
        wr_t w;
        logic [1:0] o;
        logic de;
        if (bus.mem_we === 1'b1) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write", 32'(bus.mem_addr), 32'h0000_ffff);
            end else begin
                w = exp_wr.pop_front();
                check("wr_addr", 32'(bus.mem_addr), 32'(w.addr));
                check("wr_data", 32'(bus.mem_wdata), 32'(w.data));
                check("ready_in_write", 32'(bus.in_ready), 32'd0);
            end
        end
        de = load_done | load_err;
        if (de === 1'b1 && prev_end !== 1'b1) begin
            if (exp_out.size() == 0) begin
                check("unexpected_end", {30'd0, load_done, load_err}, 32'd0);
            end else begin
                o = exp_out.pop_front();
                check("end_done", 32'(load_done), 32'(o[1]));
                check("end_err", 32'(load_err), 32'(o[0]));
                check("end_cpu_rst", 32'(cpu_rst), 32'(!o[1]));
                check("writes_pending_at_end", 32'(exp_wr.size()), 32'd0);
            end
        end
        prev_end = de;
    end

    // Frame-level reference: walk the bytes the way the frame format defines them.
    task automatic model_frame(output bit has_out);
        int i, n, sum, lo, hi, c;
        has_out = 0;
        i = 0;
        while (i < frame.size() && frame[i] != 8'hA5) i++;
        if (i >= frame.size()) begin
            consumed = i;
            return;
        end
        has_out = 1;
        i++;
        lo = frame[i++];
        hi = frame[i++];
        sum = lo + hi;
        if (hi > 3) begin
            consumed = i;
            exp_out.push_back(2'b01);
            return;
        end
        n = hi * 256 + lo;
        for (int k = 0; k < n; k++) begin
            lo = frame[i++];
            hi = frame[i++];
            sum += lo + hi;
            if (hi > 3) begin
                consumed = i;
                exp_out.push_back(2'b01);
                return;
            end
            exp_wr.push_back('{addr: 10'(k), data: 10'(hi * 256 + lo)});
        end
        c = frame[i++];
        consumed = i;
        exp_out.push_back((c == sum % 256) ? 2'b10 : 2'b01);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        start = ($urandom_range(0, 7) == 0);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        start = 1'b0;
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
    endtask

    task automatic wait_end_and_rearm();
        int n;
        n = 0;
        while (!(load_done || load_err) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("outcome_timeout", 32'd0, 32'd1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame();
        bit has_out;
        model_frame(has_out);
        for (int i = 0; i < consumed; i++) send_byte(frame[i]);
        if (has_out) wait_end_and_rearm();
    endtask

    // kind: 0-2 good, 3 bad LEN_HI, 4 bad W_HI, 5 bad checksum
    task automatic build_frame(input int n, input int kind);
        logic [7:0] lo, hi, sum;
        int bad_k;
        frame.delete();
        repeat ($urandom_range(0, 2)) begin
            lo = 8'($urandom);
            if (lo == 8'hA5) lo = 8'h5A;
            frame.push_back(lo);
        end
        frame.push_back(8'hA5);
        lo = n[7:0];
        hi = {6'd0, n[9:8]};
        if (kind == 3) hi[7:2] = 6'($urandom_range(1, 63));
        frame.push_back(lo);
        frame.push_back(hi);
        sum = lo + hi;
        bad_k = (kind == 4 && n > 0) ? $urandom_range(0, n - 1) : -1;
        for (int k = 0; k < n; k++) begin
            lo = 8'($urandom);
            hi = 8'($urandom_range(0, 3));
            if (k == bad_k) hi[7:2] = 6'($urandom_range(1, 63));
            frame.push_back(lo);
            frame.push_back(hi);
            sum = sum + lo + hi;
        end
        frame.push_back(sum + ((kind == 5) ? 8'd1 : 8'd0));
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        rst = 1'b1;

        // Nominal load, bad checksum, junk + empty frame, illegal W_HI.
        frame = '{8'hA5, 8'h02, 8'h00, 8'h8B, 8'h01, 8'h03, 8'h02, 8'h93};
        run_frame();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h8B, 8'h01, 8'h03, 8'h02, 8'h94};
        run_frame();
        frame = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame();
        frame = '{8'hA5, 8'h01, 8'h00, 8'h12, 8'h04};
        run_frame();

        // Timeout after LEN_LO, then re-arm and reload.
        exp_out.push_back(2'b01);
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (999) @(posedge clk);
        #1;
        check("timeout_999_err", 32'(load_err), 32'd0);
        @(posedge clk);
        #1;
        check("timeout_1000_err", 32'(load_err), 32'd1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rearm_in_ready", 32'(bus.in_ready), 32'd1);
        check("rearm_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rearm_err", 32'(load_err), 32'd0);
        frame = '{8'hA5, 8'h02, 8'h00, 8'h8B, 8'h01, 8'h03, 8'h02, 8'h93};
        run_frame();

        // Reset right after the first write of a frame.
        exp_wr.push_back('{addr: 10'h000, data: 10'h18B});
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h8B);
        send_byte(8'h01);
        n = 0;
        while (!bus.mem_we && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("first_write_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_mem_we", 32'(bus.mem_we), 32'd0);
        check("midrst_done_err", {30'd0, load_done, load_err}, 32'd0);
        check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
        send_byte(8'h03);
        send_byte(8'h02);
        send_byte(8'h93);
        repeat (20) @(negedge clk);

        // Largest frame, then randomised frames with gaps and corruptions.
        max_gap = 0;
        build_frame(1023, 0);
        run_frame();
        for (int f = 0; f < 30; f++) begin
            max_gap = $urandom_range(0, 3);
            build_frame(($urandom_range(0, 7) == 0) ? $urandom_range(8, 40) : $urandom_range(0, 6),
                        $urandom_range(0, 5));
            run_frame();
        end

        repeat (10) @(negedge clk);
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        check("out_queue_empty", 32'(exp_out.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL global_watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5: the frame start marker.
REQ-002 Parameter TIMEOUT_CYC, default 1000: the maximum number of idle cycles allowed between bytes inside a frame.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 in_data  input  8  serial byte stream carrying the program image.
REQ-006 in_valid  input  1  in_data holds a byte.
REQ-007 in_ready  output  1  the loader can accept a byte; a transfer occurs when in_valid and in_ready are both high.
REQ-008 start  input  1  single-cycle pulse that re-arms the loader from DONE or ERR.
REQ-009 mem_we  output  1  write strobe to the program-memory write port.
REQ-010 mem_addr  output  10  write address for program memory.
REQ-011 mem_wdata  output  10  instruction word to write.
REQ-012 cpu_rst  output  1  active-high reset that holds the 10-bit CPU while loading.
REQ-013 load_done  output  1  the image was loaded and its checksum verified.
REQ-014 load_err  output  1  a frame error was detected.

Function
REQ-015 The frame format shall be: SYNC, LEN_LO, LEN_HI, then N pairs of (W_LO, W_HI), then CSUM.
- N = {LEN_HI[1:0], LEN_LO}, range 0..1023.
- Each word = {W_HI[1:0], W_LO}.
REQ-016 The FSM shall have these states: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CSUM, DONE, ERR.
REQ-017 IDLE behaviour:
- A byte equal to SYNC_BYTE moves the FSM to LEN_LO.
- Any other byte is accepted and discarded, and the FSM stays in IDLE.
REQ-018 Length decode:
- LEN_HI with bits [7:2] nonzero goes to ERR.
- Otherwise N == 0 goes to CSUM, and N > 0 goes to DATA_LO.
REQ-019 Word decode:
- A W_HI byte with bits [7:2] nonzero goes to ERR.
- Otherwise the FSM latches the word and goes to WRITE.
REQ-020 WRITE lasts exactly one cycle:
- mem_we = 1, mem_addr = word index (first word at 0), mem_wdata = the latched word.
- The word index then increments.
- After the N-th write the FSM goes to CSUM; otherwise it goes to DATA_LO.
REQ-021 in_ready shall be 1 in IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI and CSUM, and 0 in WRITE, DONE and ERR.
REQ-022 The running checksum shall be the 8-bit sum, modulo 256, of every byte from LEN_LO through the last W_HI; SYNC and CSUM are excluded.
REQ-023 CSUM resolution: a received byte equal to the running sum goes to DONE; any other value goes to ERR.
REQ-024 Timeout:
- An idle counter counts cycles in LEN_LO, LEN_HI, DATA_LO, DATA_HI and CSUM with no transfer.
- It clears on each transfer.
- When the count reaches TIMEOUT_CYC the FSM goes to ERR.
- The counter does not run in IDLE.
REQ-025 Output levels by state:
- cpu_rst = 1 in every state except DONE.
- load_done = 1 only in DONE.
- load_err = 1 only in ERR.
REQ-026 DONE and ERR shall be held until a start pulse arrives, which moves the FSM to IDLE and clears the word index, the checksum and the idle counter.
REQ-027 start shall be ignored in all states other than DONE and ERR.
REQ-028 mem_we shall never be asserted outside WRITE, and at most N writes shall occur per frame.
REQ-029 Program memory contents written before an ERR shall be left in place, and no write shall be undone.

Reset
REQ-030 With rst = 0 at a rising edge, the block shall take these values on the next cycle:
- FSM = IDLE.
- mem_we = 0, mem_addr = 0, mem_wdata = 0.
- cpu_rst = 1, load_done = 0, load_err = 0, in_ready = 1.
- Word index, checksum and idle counter = 0.
REQ-031 A reset asserted mid-frame (including during WRITE) shall abort the frame, with no further mem_we pulse after the reset cycle.

Verification
REQ-032 Nominal load: A5, 02, 00, 8B, 01, 03, 02, CSUM 93 -> two writes, each one cycle with mem_we = 1:
- addr 0 = 10'h18B.
- addr 1 = 10'h203.
- Then load_done = 1 and cpu_rst = 0.
REQ-033 Bad checksum: the same frame with CSUM 94 -> the two writes still occur, then load_err = 1 and cpu_rst stays 1.
REQ-034 Empty and junk handling:
- Junk bytes 00 and FF before A5 are discarded.
- Then 00, 00, CSUM 00 -> zero writes and load_done = 1.
REQ-035 Illegal high byte: A5, 01, 00, 12, 04 -> ERR with no mem_we, because W_HI bits [7:2] are nonzero.
REQ-036 Timeout and re-arm:
- A5, 01, then in_valid held low for 1000 cycles -> load_err = 1.
- A start pulse then returns the loader to IDLE with cpu_rst = 1, and a new nominal frame loads correctly.
REQ-037 Back-pressure and mid-frame reset:
- With in_valid held high during WRITE, no byte is consumed (in_ready = 0).
- rst = 0 asserted right after the first write -> the FSM returns to IDLE with no further writes.
